// File: rtl/bexkat1_operand_fwd_pkg.sv
// bexkat1_operand_fwd_pkg: forward-select encoding shared with the hazard detector
package bexkat1_operand_fwd_pkg;
  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_EXE, FWD_WB} fwd_sel_t;
endpackage

// File: rtl/bexkat1_operand_fwd_if.sv
// bexkat1_operand_fwd_if: ID-side inputs, forwarding sources and EXE-side outputs of the ID/EXE stage
interface bexkat1_operand_fwd_if #(parameter int DW = 32, parameter int CW = 32);
  logic [63:0] id_ir;
  logic [DW-1:0] id_data1;
  logic [DW-1:0] id_data2;
  bexkat1_operand_fwd_pkg::fwd_sel_t hazard1;
  bexkat1_operand_fwd_pkg::fwd_sel_t hazard2;
  logic stall;
  logic flush;
  logic [DW-1:0] exe_result;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] wb_result;
  logic [63:0] exe_ir;
  logic [DW-1:0] exe_data1;
  logic [DW-1:0] exe_data2;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] bubble_count;
  modport master (output id_ir, id_data1, id_data2, hazard1, hazard2, stall, flush, exe_result, mem_result, wb_result,
                  input exe_ir, exe_data1, exe_data2, stall_count, bubble_count);
  modport slave (input id_ir, id_data1, id_data2, hazard1, hazard2, stall, flush, exe_result, mem_result, wb_result,
                 output exe_ir, exe_data1, exe_data2, stall_count, bubble_count);
endinterface

// File: rtl/bexkat1_fwd_mux.sv
// bexkat1_fwd_mux: picks one EXE operand from regfile, held WB value or an in-flight result
module bexkat1_fwd_mux import bexkat1_operand_fwd_pkg::*; #(parameter int DW = 32) (
  input  fwd_sel_t        i_sel,
  input  logic [DW-1:0]   i_id_data,
  input  logic            i_hold_valid,
  input  logic [DW-1:0]   i_hold_data,
  input  logic [DW-1:0]   i_exe_result,
  input  logic [DW-1:0]   i_mem_result,
  input  logic [DW-1:0]   i_wb_result,
  output logic [DW-1:0]   o_data
);
  // live results always beat the hold; the hold only replaces the regfile read
  always_comb
    o_data = i_sel == FWD_MEM ? i_mem_result :
             i_sel == FWD_EXE ? i_exe_result :
             i_sel == FWD_WB  ? i_wb_result  :
             i_hold_valid     ? i_hold_data  : i_id_data;
endmodule

// File: rtl/bexkat1_operand_fwd.sv
// bexkat1_operand_fwd: ID/EXE pipeline register with operand forwarding, bubble insertion and stall counters
module bexkat1_operand_fwd import bexkat1_operand_fwd_pkg::*; #(parameter int DW = 32, parameter int CW = 32) (
  input logic clk_i,
  input logic rst_i,
  bexkat1_operand_fwd_if.slave bus
);
  logic [63:0] r_exe_ir;
  logic [DW-1:0] r_exe_data1, r_exe_data2, r_hold_data1, r_hold_data2;
  logic r_hold_valid1, r_hold_valid2;
  logic [CW-1:0] r_stall_count, r_bubble_count;
  logic [DW-1:0] w_fwd1, w_fwd2;
  logic [CW-1:0] w_stall_inc, w_bubble_inc;
  logic w_bubble, w_hold, w_cap1, w_cap2;

  bexkat1_fwd_mux #(.DW(DW)) u_mux1 (.i_sel(bus.hazard1), .i_id_data(bus.id_data1), .i_hold_valid(r_hold_valid1),
    .i_hold_data(r_hold_data1), .i_exe_result(bus.exe_result), .i_mem_result(bus.mem_result),
    .i_wb_result(bus.wb_result), .o_data(w_fwd1));
  bexkat1_fwd_mux #(.DW(DW)) u_mux2 (.i_sel(bus.hazard2), .i_id_data(bus.id_data2), .i_hold_valid(r_hold_valid2),
    .i_hold_data(r_hold_data2), .i_exe_result(bus.exe_result), .i_mem_result(bus.mem_result),
    .i_wb_result(bus.wb_result), .o_data(w_fwd2));

  // flush outranks stall, so a stall only counts and captures when no flush is present
  assign w_bubble = bus.flush | bus.stall;
  assign w_hold = bus.stall & ~bus.flush;
  assign w_cap1 = w_hold & (bus.hazard1 == FWD_WB);
  assign w_cap2 = w_hold & (bus.hazard2 == FWD_WB);
  assign w_stall_inc = &r_stall_count ? r_stall_count : r_stall_count + CW'(1);
  assign w_bubble_inc = &r_bubble_count ? r_bubble_count : r_bubble_count + CW'(1);

  // pipeline, hold and counter registers; any non-stall cycle drops the holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exe_ir <= '0;
      r_exe_data1 <= '0;
      r_exe_data2 <= '0;
      r_hold_valid1 <= 1'b0;
      r_hold_valid2 <= 1'b0;
      r_hold_data1 <= '0;
      r_hold_data2 <= '0;
      r_stall_count <= '0;
      r_bubble_count <= '0;
    end else begin
      r_exe_ir <= w_bubble ? '0 : bus.id_ir;
      r_exe_data1 <= w_bubble ? '0 : w_fwd1;
      r_exe_data2 <= w_bubble ? '0 : w_fwd2;
      r_hold_valid1 <= w_hold & (w_cap1 | r_hold_valid1);
      r_hold_valid2 <= w_hold & (w_cap2 | r_hold_valid2);
      r_hold_data1 <= w_cap1 ? bus.wb_result : r_hold_data1;
      r_hold_data2 <= w_cap2 ? bus.wb_result : r_hold_data2;
      r_stall_count <= w_hold ? w_stall_inc : r_stall_count;
      r_bubble_count <= w_bubble ? w_bubble_inc : r_bubble_count;
    end
  end

  assign bus.exe_ir = r_exe_ir;
  assign bus.exe_data1 = r_exe_data1;
  assign bus.exe_data2 = r_exe_data2;
  assign bus.stall_count = r_stall_count;
  assign bus.bubble_count = r_bubble_count;
endmodule
